// File: rtl/diff_to_bcd_pkg.sv
// Shared constants and state encoding for the diff_to_bcd binary-to-BCD converter.
package diff_to_bcd_pkg;

    localparam int         CALC_WIDTH  = 8;
    localparam int         BCD_DIGITS  = 3;
    localparam logic [3:0] SHIFT_COUNT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/diff_to_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/diff_to_bcd.sv
// Sequential 8-bit binary (unsigned or two's complement) to sign + 3-digit BCD converter.
// One double-dabble bit per clock; results are held between conversions.
module diff_to_bcd
    import diff_to_bcd_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] Value,
    output logic             Busy,
    output logic             Done,
    output logic             Neg,
    output logic [3:0]       Hundreds,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones
);

    state_t state, state_nxt;

    logic [3:0]        bit_cnt;
    logic [WIDTH-1:0]  mag_sr;
    logic [3:0]        hund, tens, ones;
    logic              sign_lat;

    logic [3:0]        adj_h, adj_t, adj_o;
    logic              unused_hund_msb;

    logic signed [WIDTH-1:0] value_s;
    logic                    neg_in;
    logic [WIDTH-1:0]        mag_in;

    // Negating -128 wraps back to 0x80, which read unsigned is exactly 128.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic                    neg);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return neg ? WIDTH'(n) : WIDTH'(v);
    endfunction

    assign value_s = Value;
    assign neg_in  = Signed_Mode & Value[WIDTH-1];
    assign mag_in  = magnitude(value_s, neg_in);

    bcd_digit_adj u_adj_h (.digit(hund), .adjusted(adj_h));
    bcd_digit_adj u_adj_t (.digit(tens), .adjusted(adj_t));
    bcd_digit_adj u_adj_o (.digit(ones), .adjusted(adj_o));

    // Hundreds never exceeds 2 before correction, so its adjusted MSB never shifts out.
    assign unused_hund_msb = adj_h[3];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (Start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == SHIFT_COUNT - 4'd1) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Busy and Done are registered views of the state, one cycle behind it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state == ST_SHIFT);
            Done <= (state == ST_DONE);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt  <= 4'd0;
            mag_sr   <= '0;
            hund     <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            sign_lat <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mag_sr   <= mag_in;
                        sign_lat <= neg_in;
                        hund     <= 4'd0;
                        tens     <= 4'd0;
                        ones     <= 4'd0;
                        bit_cnt  <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    {hund, tens, ones, mag_sr} <= {adj_h[2:0], adj_t, adj_o, mag_sr, 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Neg      <= 1'b0;
            Hundreds <= 4'd0;
            Tens     <= 4'd0;
            Ones     <= 4'd0;
        end else if (state == ST_DONE) begin
            Neg      <= sign_lat;
            Hundreds <= hund;
            Tens     <= tens;
            Ones     <= ones;
        end
    end

endmodule

// File: tb/tb_diff_to_bcd.sv
// Directed and sweep bench for diff_to_bcd: latency, handshake, abort and value checks.
module tb_diff_to_bcd;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic       Signed_Mode;
    logic [7:0] Value;
    logic       Busy, Done, Neg;
    logic [3:0] Hundreds, Tens, Ones;

    logic [12:0] res;
    int          total = 0;
    int          bad   = 0;

    assign res = {Neg, Hundreds, Tens, Ones};

    diff_to_bcd #(.WIDTH(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Signed_Mode(Signed_Mode),
        .Value      (Value),
        .Busy       (Busy),
        .Done       (Done),
        .Neg        (Neg),
        .Hundreds   (Hundreds),
        .Tens       (Tens),
        .Ones       (Ones)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ref_bcd(input logic sm, input logic [7:0] v);
        logic n;
        int   m;
        n = sm & v[7];
        m = n ? 256 - int'(v) : int'(v);
        return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Start one conversion; lat = ticks after the acceptance edge until Done (99 if none).
    task automatic run_conv(input logic sm, input logic [7:0] v, output int lat, output int busy_n);
        Signed_Mode = sm;
        Value       = v;
        Start       = 1'b1;
        tick();
        Start  = 1'b0;
        lat    = 99;
        busy_n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Busy) busy_n++;
            if (Done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic conv_chk(input string tag, input logic sm, input logic [7:0] v,
                            input logic [12:0] exp);
        int lat, busy_n;
        run_conv(sm, v, lat, busy_n);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_busy"}, busy_n, 8);
        chk({tag, "_res"}, res, exp);
        tick();
        chk({tag, "_done_pulse"}, Done, 0);
        chk({tag, "_held"}, res, exp);
    endtask

    initial begin
        int nd, dpos, held_bad, lat;
        logic [12:0] got;

        Rst = 1'b1; Start = 1'b0; Signed_Mode = 1'b0; Value = 8'h00;
        tick();
        tick();
        Rst = 1'b0;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_neg", Neg, 0);
        chk("rst_hund", Hundreds, 0);
        chk("rst_tens", Tens, 0);
        chk("rst_ones", Ones, 0);

        conv_chk("u_ff", 1'b0, 8'hFF, {1'b0, 4'd2, 4'd5, 4'd5});
        conv_chk("s_80", 1'b1, 8'h80, {1'b1, 4'd1, 4'd2, 4'd8});
        conv_chk("s_f6", 1'b1, 8'hF6, {1'b1, 4'd0, 4'd1, 4'd0});
        conv_chk("s_7f", 1'b1, 8'h7F, {1'b0, 4'd1, 4'd2, 4'd7});
        conv_chk("s_00", 1'b1, 8'h00, {1'b0, 4'd0, 4'd0, 4'd0});
        conv_chk("u_80", 1'b0, 8'h80, {1'b0, 4'd1, 4'd2, 4'd8});

        // A second Start during SHIFT must be ignored, not queued.
        Signed_Mode = 1'b1; Value = 8'h05; Start = 1'b1;
        tick();
        nd = 0; dpos = 0; held_bad = 0; got = '0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                Start = 1'b1; Signed_Mode = 1'b0; Value = 8'h99;
            end else begin
                Start = 1'b0;
            end
            tick();
            if (Done) begin
                nd++;
                dpos = i;
                got  = res;
            end
            if (i < 9 && res !== {1'b0, 4'd1, 4'd2, 4'd8}) held_bad++;
        end
        chk("repulse_held", held_bad, 0);
        chk("repulse_ndone", nd, 1);
        chk("repulse_pos", dpos, 9);
        chk("repulse_res", got, {1'b0, 4'd0, 4'd0, 4'd5});

        // Reset mid-conversion aborts and clears the outputs.
        Signed_Mode = 1'b1; Value = 8'h80; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_res", res, 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Done || res !== 13'd0) nd++;
        end
        chk("abort_quiet", nd, 0);
        conv_chk("after_rst", 1'b0, 8'd42, {1'b0, 4'd0, 4'd4, 4'd2});

        // Start held high: every Done is 10 ticks after the previous one.
        Start = 1'b1;
        for (int c = 0; c < 512; c++) begin
            Signed_Mode = (c >= 256);
            Value       = 8'(c);
            lat = 0;
            for (int i = 1; i <= 12; i++) begin
                tick();
                if (Done) begin
                    lat = i;
                    break;
                end
            end
            if (c == 511) Start = 1'b0;
            chk($sformatf("sweep_gap_%0d", c), lat, 10);
            chk($sformatf("sweep_res_%0d", c), res, ref_bcd(c >= 256, 8'(c)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
